// File: rtl/s2_frame_receiver_if.sv
// S1->S2 link bundle: serial frame input plus the RB2 single-port memory port.
// The environment drives the master side; the receiver is the slave.
interface s2_frame_receiver_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 18
);
  logic              sen;
  logic              sd;
  logic              RB2_RW;
  logic [ADDR_W-1:0] RB2_A;
  logic [DATA_W-1:0] RB2_D;
  logic [DATA_W-1:0] RB2_Q;
  logic              S2_done;

  modport master (
    output sen, sd, RB2_Q,
    input  RB2_RW, RB2_A, RB2_D, S2_done
  );

  modport slave (
    input  sen, sd, RB2_Q,
    output RB2_RW, RB2_A, RB2_D, S2_done
  );
endinterface

// File: rtl/s2_frame_receiver.sv
// Deserialises MSB-first {addr,data} frames from the sen/sd link and writes each
// one into RB2 with a one-cycle active-low write strobe; flags completion on S2_done.
module s2_frame_receiver #(
  parameter int ADDR_W     = 3,
  parameter int DATA_W     = 18,
  parameter int NUM_FRAMES = 8
) (
  input logic                 clk,
  input logic                 rst,
  s2_frame_receiver_if.slave  bus
);

  localparam int FRAME_W = ADDR_W + DATA_W;
  localparam int BCNT_W  = $clog2(FRAME_W + 1);
  localparam int FCNT_W  = $clog2(NUM_FRAMES + 1);

  localparam logic [BCNT_W-1:0] LAST_BIT     = BCNT_W'(FRAME_W - 1);
  localparam logic [FCNT_W-1:0] FRAMES_TOTAL = FCNT_W'(NUM_FRAMES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  state_t              r_state;
  logic [FRAME_W-2:0]  r_shift;
  logic [BCNT_W-1:0]   r_bit_cnt;
  logic [FCNT_W-1:0]   r_frame_cnt;
  logic                r_rw;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;
  logic                r_done;

  // Only the oldest FRAME_W-1 bits are held; the current sd completes the frame.
  logic [FRAME_W-1:0]  w_frame;
  logic                w_unused;

  assign w_frame  = {r_shift, bus.sd};
  assign w_unused = ^bus.RB2_Q;

  // Frame FSM with registered memory-port and done outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_frame_cnt <= '0;
      r_rw        <= 1'b1;
      r_addr      <= '0;
      r_data      <= '0;
      r_done      <= 1'b0;
    end else begin
      r_rw <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (!bus.sen) begin
            r_shift   <= {{(FRAME_W-2){1'b0}}, bus.sd};
            r_bit_cnt <= BCNT_W'(1);
            r_state   <= ST_SHIFT;
          end else begin
            r_bit_cnt <= '0;
            r_state   <= ST_IDLE;
          end
        end

        ST_SHIFT: begin
          if (bus.sen) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_state   <= ST_IDLE;
          end else begin
            r_shift <= w_frame[FRAME_W-2:0];
            if (r_bit_cnt == LAST_BIT) begin
              r_addr      <= w_frame[FRAME_W-1:DATA_W];
              r_data      <= w_frame[DATA_W-1:0];
              r_rw        <= 1'b0;
              r_frame_cnt <= r_frame_cnt + FCNT_W'(1);
              r_bit_cnt   <= '0;
              r_state     <= ST_DRAIN;
            end else begin
              r_bit_cnt <= r_bit_cnt + BCNT_W'(1);
            end
          end
        end

        ST_DRAIN: begin
          if (bus.sen) begin
            if (r_frame_cnt == FRAMES_TOTAL) begin
              r_state <= ST_FIN;
              // If the final write strobe is still active, done follows one cycle later.
              if (r_rw) begin
                r_done <= 1'b1;
              end else begin
                r_done <= 1'b0;
              end
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_state <= ST_DRAIN;
          end
        end

        ST_FIN: begin
          r_done  <= 1'b1;
          r_state <= ST_FIN;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.RB2_RW  = r_rw;
  assign bus.RB2_A   = r_addr;
  assign bus.RB2_D   = r_data;
  assign bus.S2_done = r_done;

endmodule

// File: tb/tb_s2_frame_receiver.sv
// Scoreboard bench for s2_frame_receiver: expected RB2 writes are queued as frames
// are sent and matched against write strobes seen on the memory port.
module tb_s2_frame_receiver;

  localparam int ADDR_W     = 3;
  localparam int DATA_W     = 18;
  localparam int NUM_FRAMES = 8;
  localparam int FRAME_W    = ADDR_W + DATA_W;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  s2_frame_receiver_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  s2_frame_receiver #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .NUM_FRAMES(NUM_FRAMES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always @(posedge clk) begin
    if (bus.RB2_RW === 1'b0) mem[bus.RB2_A] <= bus.RB2_D;
  end
  assign bus.RB2_Q = mem[bus.RB2_A];

  logic [FRAME_W-1:0] exp_q[$];
  logic [FRAME_W-1:0] obs_q[$];
  int vectors     = 0;
  int miscompares = 0;

  always @(negedge clk) begin
    if (rst === 1'b0 && bus.RB2_RW === 1'b0) obs_q.push_back({bus.RB2_A, bus.RB2_D});
  end

  task automatic drive_bit(input logic s, input logic d);
    bus.sen = s;
    bus.sd  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [FRAME_W-1:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) drive_bit(1'b0, f[FRAME_W-1-i]);
  endtask

  task automatic send_frame(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                            input bit expect_write);
    if (expect_write) exp_q.push_back({a, d});
    send_bits({a, d}, FRAME_W);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) begin
      bus.sen = 1'($urandom());
      bus.sd  = 1'($urandom());
      @(posedge clk);
      #1;
    end
    rst     = 1'b0;
    bus.sen = 1'b1;
    bus.sd  = 1'b0;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      bus.sen = 1'($urandom());
      bus.sd  = 1'($urandom());
      @(negedge clk);
      vectors++;
      if ({bus.RB2_RW, bus.RB2_A, bus.RB2_D, bus.S2_done} !== {1'b1, 3'd0, 18'd0, 1'b0}) begin
        miscompares++;
        $display("FAIL reset_outputs: got RW=%b A=%0d D=%h done=%b, expected RW=1 A=0 D=0 done=0",
                 bus.RB2_RW, bus.RB2_A, bus.RB2_D, bus.S2_done);
      end
      @(posedge clk);
      #1;
    end
    rst     = 1'b0;
    bus.sen = 1'b1;
    bus.sd  = 1'b0;
    exp_q.delete();
    obs_q.delete();
    drive_bit(1'b1, 1'b0);
  endtask

  task automatic test_single_frame();
    logic [FRAME_W-1:0] e, o;
    send_frame(3'b101, 18'h2A5C3, 1'b1);
    vectors++;
    if ({bus.RB2_RW, bus.RB2_A, bus.RB2_D} !== {1'b0, 3'd5, 18'h2A5C3}) begin
      miscompares++;
      $display("FAIL single_strobe: got RW=%b A=%0d D=%h, expected RW=0 A=5 D=2a5c3",
               bus.RB2_RW, bus.RB2_A, bus.RB2_D);
    end
    drive_bit(1'b1, 1'b0);
    vectors++;
    if ({bus.RB2_RW, bus.S2_done} !== 2'b10) begin
      miscompares++;
      $display("FAIL single_release: got RW=%b done=%b, expected RW=1 done=0", bus.RB2_RW, bus.S2_done);
    end
    drive_bit(1'b1, 1'b0);
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL single_count: got %0d writes, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL single_write: got %h, expected %h", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_short_frame();
    logic [FRAME_W-1:0] e, o;
    send_bits({3'd6, 18'h15555}, 10);
    drive_bit(1'b1, 1'b0);
    send_frame(3'd2, 18'h0BEEF, 1'b1);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b0);
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL short_count: got %0d writes, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL short_write: got %h, expected %h", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
    vectors++;
    if (mem[2] !== 18'h0BEEF) begin
      miscompares++;
      $display("FAIL short_mem: got %h, expected 0beef", mem[2]);
    end
  endtask

  task automatic test_long_enable();
    logic [FRAME_W-1:0] e, o;
    send_frame(3'd7, 18'h1ABCD, 1'b1);
    repeat (4) drive_bit(1'b0, 1'($urandom()));
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b0);
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL long_count: got %0d writes, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL long_write: got %h, expected %h", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  // Three frames are already counted; four more leave done low, the eighth raises it late.
  task automatic test_frame_count();
    logic [FRAME_W-1:0] e, o;
    for (int n = 0; n < 4; n++) begin
      send_frame(3'(n), 18'h00A00 + 18'(n), 1'b1);
      drive_bit(1'b1, 1'b0);
      vectors++;
      if (bus.S2_done !== 1'b0) begin
        miscompares++;
        $display("FAIL count_early_done: frame %0d got done=%b, expected 0", n, bus.S2_done);
      end
    end
    send_frame(3'd4, 18'h24680, 1'b1);
    for (int c = 0; c < 3; c++) begin
      drive_bit(1'b0, 1'($urandom()));
      vectors++;
      if (bus.S2_done !== 1'b0) begin
        miscompares++;
        $display("FAIL count_drain_done: cycle %0d got done=%b, expected 0", c, bus.S2_done);
      end
    end
    drive_bit(1'b1, 1'b0);
    vectors++;
    if (bus.S2_done !== 1'b1) begin
      miscompares++;
      $display("FAIL count_late_done: got done=%b, expected 1", bus.S2_done);
    end
    send_frame(3'd1, 18'h12345, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b0);
    vectors++;
    if ({bus.S2_done, mem[1]} !== {1'b1, 18'h00A01}) begin
      miscompares++;
      $display("FAIL fin_ignore: got done=%b mem1=%h, expected done=1 mem1=00a01", bus.S2_done, mem[1]);
    end
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL count_writes: got %0d writes, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL count_write: got %h, expected %h", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_full_run();
    logic [FRAME_W-1:0] e, o;
    do_reset();
    for (int n = 0; n < NUM_FRAMES; n++) begin
      send_frame(3'(n), 18'h3FFFF - 18'(n), 1'b1);
      if (n < NUM_FRAMES - 1) begin
        drive_bit(1'b1, 1'b0);
        vectors++;
        if (bus.S2_done !== 1'b0) begin
          miscompares++;
          $display("FAIL full_early_done: frame %0d got done=%b, expected 0", n, bus.S2_done);
        end
      end
    end
    vectors++;
    if ({bus.RB2_RW, bus.S2_done} !== 2'b00) begin
      miscompares++;
      $display("FAIL full_k: got RW=%b done=%b, expected RW=0 done=0", bus.RB2_RW, bus.S2_done);
    end
    drive_bit(1'b1, 1'b0);
    vectors++;
    if ({bus.RB2_RW, bus.S2_done} !== 2'b10) begin
      miscompares++;
      $display("FAIL full_k1: got RW=%b done=%b, expected RW=1 done=0", bus.RB2_RW, bus.S2_done);
    end
    drive_bit(1'b1, 1'b0);
    vectors++;
    if (bus.S2_done !== 1'b1) begin
      miscompares++;
      $display("FAIL full_k2_done: got done=%b, expected 1", bus.S2_done);
    end
    repeat (5) drive_bit(1'($urandom()), 1'($urandom()));
    vectors++;
    if ({bus.RB2_RW, bus.S2_done} !== 2'b11) begin
      miscompares++;
      $display("FAIL full_hold: got RW=%b done=%b, expected RW=1 done=1", bus.RB2_RW, bus.S2_done);
    end
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL full_count: got %0d writes, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL full_write: got %h, expected %h", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
    for (int n = 0; n < NUM_FRAMES; n++) begin
      vectors++;
      if (mem[n] !== 18'h3FFFF - 18'(n)) begin
        miscompares++;
        $display("FAIL full_mem: addr %0d got %h, expected %h", n, mem[n], 18'h3FFFF - 18'(n));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [FRAME_W-1:0] e, o;
    logic [FRAME_W-1:0] f;
    do_reset();
    for (int n = 0; n < 4; n++) begin
      send_frame(3'(n), 18'h01000 + 18'(n), 1'b1);
      drive_bit(1'b1, 1'b0);
    end
    f = {3'd4, 18'h3AAAA};
    send_bits(f, 14);
    bus.sen = 1'b0;
    bus.sd  = f[FRAME_W-15];
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL mid_pre_count: got %0d writes, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL mid_pre_write: got %h, expected %h", o, e);
      end
    end
    do_reset();
    vectors++;
    if ({bus.RB2_RW, bus.S2_done} !== 2'b10) begin
      miscompares++;
      $display("FAIL mid_after_reset: got RW=%b done=%b, expected RW=1 done=0", bus.RB2_RW, bus.S2_done);
    end
    for (int n = 0; n < NUM_FRAMES; n++) begin
      send_frame(3'(n), 18'h20000 + 18'(n * 273), 1'b1);
      drive_bit(1'b1, 1'b0);
      if (n < NUM_FRAMES - 1) begin
        vectors++;
        if (bus.S2_done !== 1'b0) begin
          miscompares++;
          $display("FAIL mid_early_done: frame %0d got done=%b, expected 0", n, bus.S2_done);
        end
      end
    end
    drive_bit(1'b1, 1'b0);
    vectors++;
    if (bus.S2_done !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_done: got done=%b, expected 1", bus.S2_done);
    end
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL mid_count: got %0d writes, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL mid_write: got %h, expected %h", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
    for (int n = 0; n < NUM_FRAMES; n++) begin
      vectors++;
      if (mem[n] !== 18'h20000 + 18'(n * 273)) begin
        miscompares++;
        $display("FAIL mid_mem: addr %0d got %h, expected %h", n, mem[n], 18'h20000 + 18'(n * 273));
      end
    end
  endtask

  // Reset landing inside the write strobe must release RW at once and cancel the store.
  task automatic test_reset_mid_write();
    do_reset();
    send_frame(3'd3, 18'h3C3C3, 1'b0);
    vectors++;
    if (bus.RB2_RW !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_strobe: got RW=%b, expected 0", bus.RB2_RW);
    end
    rst     = 1'b1;
    bus.sen = 1'b1;
    #1;
    vectors++;
    if (bus.RB2_RW !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_async: got RW=%b, expected 1", bus.RB2_RW);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (mem[3] !== 18'h20000 + 18'(3 * 273)) begin
      miscompares++;
      $display("FAIL abort_mem: got %h, expected %h", mem[3], 18'h20000 + 18'(3 * 273));
    end
    do_reset();
  endtask

  initial begin
    rst     = 1'b1;
    bus.sen = 1'b1;
    bus.sd  = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_single_frame();
    test_short_frame();
    test_long_enable();
    test_frame_count();
    test_full_run();
    test_reset_mid();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/s2_frame_receiver.md
# s2_frame_receiver

Serial frame receiver for the S1→S2 link. It samples the `sen`/`sd` serial stream driven by the S1 transmitter and deserialises each 21-bit frame into a 3-bit address and an 18-bit data word. Each frame is written into the RB2 single-port memory at that address. After the configured number of frames has been written it raises `S2_done`, which the bench uses as the trigger to check RB2.

## Interface
- `ADDR_W`, default 3: frame address field width; also the RB2 address width.
- `DATA_W`, default 18: frame data field width; also the RB2 word width.
- `NUM_FRAMES`, default 8: number of frame writes before `S2_done` is raised.
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `sen`, input, 1: frame enable, active low. High means the link is idle or between frames.
- `sd`, input, 1: serial data, MSB first, valid while `sen`=0.
- `RB2_RW`, output, 1: memory write enable. 0 = write, 1 = read/idle.
- `RB2_A`, output, ADDR_W: memory address.
- `RB2_D`, output, DATA_W: memory write data.
- `RB2_Q`, input, DATA_W: memory read data. Unused by this block, but kept for the memory interface.
- `S2_done`, output, 1: all frames written. Sticky until reset.

## Operation
- **Frame format**: ADDR_W+DATA_W = 21 bits, sent MSB first.
  - Bits 20:18 are the address; bits 17:0 are the data.
- **Reset values**: `RB2_RW`=1, `RB2_A`=0, `RB2_D`=0, `S2_done`=0. Bit counter, frame counter and shift register are cleared; state is IDLE.
- **States**:
  - IDLE: wait for `sen`=0.
  - SHIFT: collect bits.
  - DRAIN: frame complete; ignore bits until `sen`=1.
  - FIN: all frames written.
- **IDLE**:
  - On an edge with `sen`=0: shift in `sd` as bit 20, set the bit counter to 1, go to SHIFT.
  - On an edge with `sen`=1: stay in IDLE.
- **SHIFT**:
  - On each edge with `sen`=0: shift in `sd` and increment the bit counter.
  - When the 21st bit is captured: load `RB2_A` = bits 20:18 and `RB2_D` = bits 17:0, drive `RB2_RW`=0 for exactly one cycle, increment the frame counter, go to DRAIN.
  - Edge with `sen`=1 before the 21st bit (short frame): discard the partial frame, perform no write, clear the bit counter, go to IDLE. The frame counter is unchanged.
- **DRAIN**:
  - Edges with `sen`=0: bits ignored, no second write.
  - Edge with `sen`=1: go to IDLE, or to FIN if the frame counter equals NUM_FRAMES.
- **Write cycle independence**: the write cycle overlaps DRAIN/IDLE; a new frame may start on the edge right after `sen` returns high.
- **Duplicate addresses**: written again (last write wins) and counted as a frame.
- **FIN**:
  - `S2_done` rises one cycle after the final write edge, so memory is updated before `S2_done` rises.
  - `sen`/`sd` are ignored; `RB2_RW` stays 1.
  - Left only by reset.
- **Reset mid-frame or mid-write**: all counters clear and the partial frame is lost. The pending write is aborted: `RB2_RW` returns to 1 immediately (asynchronous).

## Timing
- `sen`/`sd` are sampled on rising `clk`; the transmitter updates them after the edge.
- Edge k: 21st bit sampled. Edge k through k+1: `RB2_RW`=0, `RB2_A`/`RB2_D` stable. Edge k+1: RB2 stores the word; `RB2_RW` returns to 1.
- Latency from last serial bit to memory commit: 1 cycle.
- `S2_done` asserts at edge k+2 of the NUM_FRAMES-th frame's write, or at the edge on which DRAIN sees `sen`=1, whichever is later.
- Minimum spacing between frames: 1 cycle with `sen`=1. Back-to-back frames then need 22 cycles each.
- All outputs are registered; no combinational path from `sen`/`sd` to any output.

## Test plan
- **Reset**: `rst`=1 for 2 cycles with random `sen`/`sd` → `RB2_RW`=1, `RB2_A`=0, `RB2_D`=0, `S2_done`=0 throughout.
- **Single frame**: send address 3'b101, data 18'h2A5C3 → exactly one `RB2_RW`=0 cycle with A=5, D=2A5C3, one cycle after the last bit; `S2_done` stays 0.
- **Full run**: frames n=0..7 with data 0x3FFFF−n, 1-cycle gaps → eight writes, mem[n] correct, `S2_done` rises 2 cycles after the 8th write cycle starts and then holds.
- **Short frame**: `sen` goes high after 10 bits, then a valid frame for address 2 → no write for the aborted frame; address 2 written once; frame count +1 only.
- **Long enable**: `sen` held low for 25 bits → one write from the first 21 bits; bits 22–25 ignored.
- **Reset mid-operation**: assert `rst` during bit 15 of frame 4, then resend frames 0..7 → `S2_done` only after 8 post-reset frames; RB2 matches the resent data.
